// File: rtl/mem_stage_sram.sv
// Memory stage: 32-bit LDR/STR against an external 16-bit SRAM, done as two
// half-word accesses with programmable wait states. ready drops while an
// access is in flight so the upstream pipeline freezes.
//
// state | meaning
// IDLE  | waiting for mem_read/mem_write; latches address and store data
// RD_LO | reading low half-word  (sram_addr = {word,0})
// RD_HI | reading high half-word (sram_addr = {word,1})
// WR_LO | writing low half-word  (store[15:0])
// WR_HI | writing high half-word (store[31:16])
// DONE  | one-cycle completion, ready=1, mem_result valid
module mem_stage_sram #(
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        alu_res,
  input  logic [31:0]        store_val,
  output logic [31:0]        mem_result,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_in,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);

  localparam int WW = SRAM_AW - 1;
  // Wait counter counts down from WAIT_CYCLES-1; zero marks the last cycle of a state.
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [WW-1:0]      word_q, word_d;
  logic [31:0]        store_q, store_d;
  logic [31:0]        result_q, result_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;
  logic               req;

  assign req = mem_read | mem_write;

  // Next-state, wait counter, request capture and read-data sampling.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    store_d  = store_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
        if (req) begin
          // Out-of-range addresses simply wrap inside the SRAM.
          word_d  = WW'((alu_res - 32'(BASE_ADDR)) >> 2);
          store_d = store_val;
          cnt_d   = WAIT_LOAD;
          state_d = mem_write ? WR_LO : RD_LO;
        end
      end
      RD_LO: begin
        if (cnt_q == 4'd0) begin
          result_d[15:0] = sram_dq_in;
          cnt_d          = WAIT_LOAD;
          state_d        = RD_HI;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RD_HI: begin
        if (cnt_q == 4'd0) begin
          result_d[31:16] = sram_dq_in;
          cnt_d           = 4'd0;
          state_d         = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_LO: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = WAIT_LOAD;
          state_d = WR_HI;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_HI: begin
        if (cnt_q == 4'd0) begin
          cnt_d   = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    endcase
  end

  // SRAM pin values for the coming cycle, derived from next state so the pins are registered.
  always_comb begin
    addr_d   = '0;
    oe_d     = 1'b0;
    dq_out_d = 16'h0000;
    we_n_d   = 1'b1;
    case (state_d)
      RD_LO: addr_d = {word_d, 1'b0};
      RD_HI: addr_d = {word_d, 1'b1};
      WR_LO: begin
        addr_d   = {word_d, 1'b0};
        oe_d     = 1'b1;
        dq_out_d = store_d[15:0];
        // Release we_n on the last cycle so data is held past the write strobe.
        we_n_d   = (cnt_d == 4'd0);
      end
      WR_HI: begin
        addr_d   = {word_d, 1'b1};
        oe_d     = 1'b1;
        dq_out_d = store_d[31:16];
        we_n_d   = (cnt_d == 4'd0);
      end
      default: ;
    endcase
  end

  // State and output registers with synchronous reset to idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      word_q   <= '0;
      store_q  <= 32'h0;
      result_q <= 32'h0;
      addr_q   <= '0;
      dq_out_q <= 16'h0000;
      oe_q     <= 1'b0;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      store_q  <= store_d;
      result_q <= result_d;
      addr_q   <= addr_d;
      dq_out_q <= dq_out_d;
      oe_q     <= oe_d;
      we_n_q   <= we_n_d;
    end
  end

  assign ready       = (state_q == DONE) | ((state_q == IDLE) & ~req);
  assign mem_result  = result_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

endmodule
